// File: rtl/var_unshift_if.sv
// Word-load and chunk-output handshake bundle for the variable-chunk unpacker.
interface var_unshift_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             dir;
  logic [CNT_W-1:0] shift;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_bits;
  logic             out_last;
  logic [CNT_W-1:0] bits_left;

  modport master (
    output load_valid, load_data, dir, shift, out_ready,
    input  load_ready, out_valid, out_data, out_bits, out_last, bits_left
  );

  modport slave (
    input  load_valid, load_data, dir, shift, out_ready,
    output load_ready, out_valid, out_data, out_bits, out_last, bits_left
  );
endinterface

// File: rtl/var_unshift.sv
// Variable-chunk parallel-to-serial unpacker: load a word, emit right-justified chunks LSB- or MSB-first.
// First chunk one cycle after load; one chunk per cycle; state holds while out_ready is low or en is low.
module var_unshift #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  var_unshift_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic             dir_r;
  logic [CNT_W-1:0] bits_left;

  logic [CNT_W-1:0] req;
  logic [CNT_W-1:0] k;
  logic [WIDTH-1:0] chunk;
  logic             out_valid;
  logic             load_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_bits;
  logic             out_last;
  logic             out_fire;
  logic             load_fire;

  // Zero requests a single bit; requests beyond what is left are clamped.
  always_comb begin
    req   = (bus.shift == '0) ? CNT_W'(1) : bus.shift;
    k     = (req > bits_left) ? bits_left : req;
    chunk = dir_r ? (sreg >> (FULL - k)) : (sreg & ~({WIDTH{1'b1}} << k));
  end

  always_comb begin
    state_nxt  = state;
    out_valid  = 1'b0;
    load_ready = 1'b0;
    out_data   = '0;
    out_bits   = '0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        load_ready = en & ~clr;
        if (en && !clr && bus.load_valid)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        out_valid  = en;
        out_data   = chunk;
        out_bits   = k;
        out_last   = (k == bits_left);
        // The final beat doubles as the load slot for the next word.
        load_ready = en & bus.out_ready & out_last;
        if (en && bus.out_ready && out_last && !bus.load_valid)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_fire  = out_valid & bus.out_ready;
  assign load_fire = load_ready & bus.load_valid;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      sreg      <= '0;
      dir_r     <= 1'b0;
      bits_left <= '0;
    end else begin
      state <= state_nxt;
      if (load_fire) begin
        sreg      <= bus.load_data;
        dir_r     <= bus.dir;
        bits_left <= FULL;
      end else if (out_fire) begin
        sreg      <= dir_r ? (sreg << k) : (sreg >> k);
        bits_left <= bits_left - k;
      end
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.load_ready = load_ready;
  assign bus.out_data   = out_data;
  assign bus.out_bits   = out_bits;
  assign bus.out_last   = out_last;
  assign bus.bits_left  = bits_left;
endmodule

// File: tb/tb_var_unshift.sv
// Directed-vector bench for var_unshift; inputs change on the falling edge, outputs are read 1 time unit later.
module tb_var_unshift;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef logic [WIDTH+CNT_W+1:0] obs_t;

  logic clk = 1'b0;
  logic clr;
  logic en;
  always #5 clk = ~clk;

  var_unshift_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u ();

  var_unshift #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .bus (u.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic test_reset();
    clr = 1'b1; en = 1'b1;
    u.load_valid = 1'b0; u.load_data = '0; u.dir = 1'b0; u.shift = '0; u.out_ready = 1'b0;
    #1;
    n_cmp++;
    if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.load_ready, u.bits_left} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h b=%0d l=%b lr=%b bl=%0d, want all zero",
               u.out_valid, u.out_data, u.out_bits, u.out_last, u.load_ready, u.bits_left);
    end
    @(negedge clk); clr = 1'b0; #1;
    n_cmp++;
    if ({u.load_ready, u.out_valid, u.bits_left} !== {1'b1, 1'b0, CNT_W'(0)}) begin
      n_err++;
      $display("FAIL reset_release: got lr=%b v=%b bl=%0d, want lr=1 v=0 bl=0",
               u.load_ready, u.out_valid, u.bits_left);
    end
    en = 1'b0; #1;
    n_cmp++;
    if (u.load_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_en_low: got load_ready=%b, want 0", u.load_ready);
    end
    en = 1'b1;
  endtask

  task automatic test_lsb_bytes();
    logic [31:0] exp_d [4] = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b0; u.shift = CNT_W'(8); u.out_ready = 1'b1;
    u.load_valid = 1'b1; u.load_data = 32'hDEADBEEF; #1;
    n_cmp++;
    if (u.load_ready !== 1'b1) begin
      n_err++; $display("FAIL lsb_load_ready: got %b, want 1", u.load_ready);
    end
    @(negedge clk); u.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_o = {1'b1, exp_d[i], CNT_W'(8), (i == 3)};
      n_cmp++;
      if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left} !== {exp_o, CNT_W'(32 - 8*i)}) begin
        n_err++;
        $display("FAIL lsb_beat%0d: got v=%b d=%h b=%0d l=%b bl=%0d, want d=%h b=8 l=%b bl=%0d", i,
                 u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left, exp_d[i], (i == 3), 32 - 8*i);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({u.out_valid, u.load_ready, u.bits_left} !== {1'b0, 1'b1, CNT_W'(0)}) begin
      n_err++;
      $display("FAIL lsb_idle: got v=%b lr=%b bl=%0d, want v=0 lr=1 bl=0", u.out_valid, u.load_ready, u.bits_left);
    end
  endtask

  task automatic test_msb_twelve();
    logic [31:0] exp_d  [3] = '{32'h123, 32'h456, 32'h78};
    int          exp_b  [3] = '{12, 12, 8};
    int          exp_bl [3] = '{32, 20, 8};
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b1; u.shift = CNT_W'(12); u.load_valid = 1'b1; u.load_data = 32'h12345678;
    @(negedge clk); u.load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_o = {1'b1, exp_d[i], CNT_W'(exp_b[i]), (i == 2)};
      n_cmp++;
      if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left} !== {exp_o, CNT_W'(exp_bl[i])}) begin
        n_err++;
        $display("FAIL msb_beat%0d: got v=%b d=%h b=%0d l=%b bl=%0d, want d=%h b=%0d l=%b bl=%0d", i,
                 u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left,
                 exp_d[i], exp_b[i], (i == 2), exp_bl[i]);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (u.out_valid !== 1'b0) begin
      n_err++; $display("FAIL msb_idle: got out_valid=%b, want 0", u.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic        rdy    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_d  [7] = '{32'h0F, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hA5, 32'hA5};
    int          exp_bl [7] = '{32, 24, 24, 24, 24, 16, 8};
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b0; u.shift = CNT_W'(8); u.load_valid = 1'b1; u.load_data = 32'hA5A5F00F;
    @(negedge clk); u.load_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      u.out_ready = rdy[i]; #1;
      exp_o = {1'b1, exp_d[i], CNT_W'(8), (i == 6)};
      n_cmp++;
      if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left} !== {exp_o, CNT_W'(exp_bl[i])}) begin
        n_err++;
        $display("FAIL stall_step%0d: got v=%b d=%h b=%0d l=%b bl=%0d, want d=%h b=8 l=%b bl=%0d", i,
                 u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left, exp_d[i], (i == 6), exp_bl[i]);
      end
      @(negedge clk);
    end
    u.out_ready = 1'b1;
  endtask

  task automatic test_shift_bounds();
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b0; u.shift = CNT_W'(0); u.load_valid = 1'b1; u.load_data = 32'h80000001;
    @(negedge clk); u.load_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp_o = {1'b1, 32'((i == 0) || (i == 31)), CNT_W'(1), (i == 31)};
      n_cmp++;
      if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left} !== {exp_o, CNT_W'(32 - i)}) begin
        n_err++;
        $display("FAIL bit_beat%0d: got v=%b d=%h b=%0d l=%b bl=%0d, want d=%0d b=1 l=%b bl=%0d", i,
                 u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left,
                 ((i == 0) || (i == 31)), (i == 31), 32 - i);
      end
      @(negedge clk);
    end
    u.shift = CNT_W'(40); u.load_valid = 1'b1; u.load_data = 32'hCAFEF00D;
    @(negedge clk); u.load_valid = 1'b0; #1;
    n_cmp++;
    if ({u.out_valid, u.out_data, u.out_bits, u.out_last} !== {1'b1, 32'hCAFEF00D, CNT_W'(32), 1'b1}) begin
      n_err++;
      $display("FAIL clamp_beat: got v=%b d=%h b=%0d l=%b, want v=1 d=cafef00d b=32 l=1",
               u.out_valid, u.out_data, u.out_bits, u.out_last);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (u.out_valid !== 1'b0) begin
      n_err++; $display("FAIL clamp_idle: got out_valid=%b, want 0", u.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d  [4] = '{32'h1111, 32'h1111, 32'h2222, 32'h2222};
    logic        exp_lr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int          exp_bl [4] = '{32, 16, 32, 16};
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b0; u.shift = CNT_W'(16); u.load_valid = 1'b1; u.load_data = 32'h11111111;
    @(negedge clk); u.load_data = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) u.load_valid = 1'b0;
      #1;
      exp_o = {1'b1, exp_d[i], CNT_W'(16), (i == 1) || (i == 3)};
      n_cmp++;
      if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left, u.load_ready} !==
          {exp_o, CNT_W'(exp_bl[i]), exp_lr[i]}) begin
        n_err++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b bl=%0d lr=%b, want v=1 d=%h l=%b bl=%0d lr=%b", i,
                 u.out_valid, u.out_data, u.out_last, u.bits_left, u.load_ready,
                 exp_d[i], (i == 1) || (i == 3), exp_bl[i], exp_lr[i]);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (u.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got out_valid=%b, want 0", u.out_valid);
    end
  endtask

  task automatic test_clr_and_en();
    logic        en_v   [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] exp_d  [6] = '{32'h88, 32'h77, 32'h66, 32'h66, 32'h66, 32'h55};
    int          exp_bl [6] = '{32, 24, 16, 16, 16, 8};
    obs_t exp_o;
    @(negedge clk);
    u.dir = 1'b0; u.shift = CNT_W'(8); u.load_valid = 1'b1; u.load_data = 32'h0A0B0C0D;
    @(negedge clk); u.load_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); clr = 1'b1; #1;
    n_cmp++;
    if ({u.out_valid, u.bits_left, u.out_data, u.load_ready} !== '0) begin
      n_err++;
      $display("FAIL clr_midword: got v=%b bl=%0d d=%h lr=%b, want all zero",
               u.out_valid, u.bits_left, u.out_data, u.load_ready);
    end
    @(negedge clk); clr = 1'b0;
    u.load_valid = 1'b1; u.load_data = 32'h55667788;
    @(negedge clk); u.load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = en_v[i]; #1;
      exp_o = {1'b1, exp_d[i], CNT_W'(8), (i == 5)};
      n_cmp++;
      if (en_v[i]) begin
        if ({u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left} !== {exp_o, CNT_W'(exp_bl[i])}) begin
          n_err++;
          $display("FAIL en_step%0d: got v=%b d=%h b=%0d l=%b bl=%0d, want v=1 d=%h b=8 l=%b bl=%0d", i,
                   u.out_valid, u.out_data, u.out_bits, u.out_last, u.bits_left, exp_d[i], (i == 5), exp_bl[i]);
        end
      end else begin
        if ({u.out_valid, u.load_ready, u.bits_left} !== {1'b0, 1'b0, CNT_W'(exp_bl[i])}) begin
          n_err++;
          $display("FAIL en_stall%0d: got v=%b lr=%b bl=%0d, want v=0 lr=0 bl=%0d", i,
                   u.out_valid, u.load_ready, u.bits_left, exp_bl[i]);
        end
      end
      @(negedge clk);
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lsb_bytes();
    test_msb_twelve();
    test_backpressure();
    test_shift_bounds();
    test_back_to_back();
    test_clr_and_en();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
